// File: rtl/cen_fracgen_if.sv
// Control/enable bundle between the clock-enable generator and its consumer.
// Ports: pause/turbo/sync strobes, per-channel num, shared den (master -> slave);
//        cen pulses and cen_any summary (slave -> master).
interface cen_fracgen_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16
);
  logic                      pause;
  logic                      turbo;
  logic                      sync;
  logic [CHANNELS*ACC_W-1:0] num;
  logic [ACC_W-1:0]          den;
  logic [CHANNELS-1:0]       cen;
  logic                      cen_any;

  // The emu top drives ratios and control and consumes the enables.
  modport master (
    output pause, turbo, sync, num, den,
    input  cen, cen_any
  );

  // The generator samples ratios and control and produces the enables.
  modport slave (
    input  pause, turbo, sync, num, den,
    output cen, cen_any
  );
endinterface

// File: rtl/cen_fracgen.sv
// Multi-channel fractional clock-enable generator: channel i pulses at clk_sys*num_i/den.
// Latency: one cycle; cen is registered and high for the cycle after the edge that crosses den.
// Backpressure: none; pause freezes every accumulator (phase kept), sync zeroes them all.
//
// Ports:
//   clk_sys  - system clock, all state on the rising edge
//   reset_n  - asynchronous active-low reset (deassertion assumed synchronised upstream)
//   bus      - slave side of cen_fracgen_if: pause, turbo, sync, num, den in; cen, cen_any out
module cen_fracgen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16,
  parameter bit TURBO_EN = 1'b1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  cen_fracgen_if.slave        bus
);

  // One bit of headroom: after den is lowered mid-run the stored remainder may
  // exceed the new den, and turbo doubles the increment.
  logic [ACC_W:0]      acc_q [CHANNELS];
  logic [ACC_W:0]      acc_d [CHANNELS];
  logic [CHANNELS-1:0] cen_q;
  logic [CHANNELS-1:0] cen_d;
  logic                cen_any_q;
  logic                cen_any_d;
  logic                turbo_eff;

  // A build without turbo ignores the input entirely.
  assign turbo_eff = TURBO_EN & bus.turbo;

  // One counting step for a single channel. Returns {pulse, next_acc}.
  function automatic logic [ACC_W+1:0] chan_step(
    input logic [ACC_W:0]   acc,
    input logic [ACC_W-1:0] num,
    input logic [ACC_W-1:0] den,
    input logic             dbl
  );
    logic [ACC_W:0]   inc;
    logic [ACC_W+1:0] sum;
    logic [ACC_W+1:0] den_x;
    logic [ACC_W+1:0] diff;
    logic [ACC_W+1:0] res;
    inc   = dbl ? {num, 1'b0} : {1'b0, num};
    sum   = {1'b0, acc} + {1'b0, inc};
    den_x = {2'b00, den};
    diff  = sum - den_x;
    res   = {1'b0, acc};
    if (den == '0) begin
      // Disabled channel: forget any phase so re-enabling starts clean.
      res = '0;
    end else if (num == '0) begin
      res = {1'b0, acc};
    end else if ({1'b0, inc} >= den_x) begin
      // Ratio >= 1: pulse every cycle, nothing to carry.
      res = {1'b1, {(ACC_W+1){1'b0}}};
    end else if (sum >= den_x) begin
      // A remainder still >= den only happens after den dropped under the
      // stored phase; discard it rather than emit a burst.
      if (diff >= den_x) begin
        res = {1'b1, {(ACC_W+1){1'b0}}};
      end else begin
        res = {1'b1, diff[ACC_W:0]};
      end
    end else begin
      res = {1'b0, sum[ACC_W:0]};
    end
    return res;
  endfunction

  // Next state: sync beats pause beats counting.
  always_comb begin
    acc_d = acc_q;
    cen_d = '0;
    if (bus.sync) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_d[i] = '0;
      end
    end else if (!bus.pause) begin
      for (int i = 0; i < CHANNELS; i++) begin
        {cen_d[i], acc_d[i]} = chan_step(acc_q[i],
                                         bus.num[i*ACC_W +: ACC_W],
                                         bus.den,
                                         turbo_eff);
      end
    end
  end

  // Summary enable is registered from the same next values so it lines up with cen.
  assign cen_any_d = |cen_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      cen_q     <= '0;
      cen_any_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cen_q     <= cen_d;
      cen_any_q <= cen_any_d;
    end
  end

  assign bus.cen     = cen_q;
  assign bus.cen_any = cen_any_q;

endmodule

// File: doc/cen_fracgen.md
Name: cen_fracgen

Overview:
- Parametrised multi-channel fractional clock-enable generator; successor to the fixed /4, /12 integer dividers that feed core clock enables from clk_sys.
- Each channel produces a one-cycle enable at average rate clk_sys*num/den from a shared denominator.
- Adds runtime ratios, turbo (x2 rate) mode for faster simulation, phase-preserving pause and synchronous phase realignment.
- Sits between the emu top and the system core; its enables replace ce_6/ce_2.

Parameters:
- CHANNELS, 2, number of independent enable outputs (1..8).
- ACC_W, 16, width of num/den and accumulator magnitude.
- TURBO_EN, 1, 1 = turbo input honoured; 0 = turbo ignored (tied off internally).

Ports:
- clk_sys  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pause  in  1  freeze all channels; phase held.
- turbo  in  1  double every channel's increment.
- sync  in  1  one-cycle strobe: zero all accumulators.
- num  in  CHANNELS*ACC_W  per-channel numerator; channel i = num[i*ACC_W +: ACC_W].
- den  in  ACC_W  shared denominator.
- cen  out  CHANNELS  per-channel registered enable pulses.
- cen_any  out  1  registered OR of all cen bits, same cycle as cen.

Behaviour:
- Reset (async assert, sync-safe release): all acc = 0, cen = 0, cen_any = 0. On reset assertion mid-run, outputs drop immediately.
- Per-channel state: acc, ACC_W+1 bits. Priority each edge: reset > sync > pause > count.
- sync = 1: acc <= 0, cen <= 0 for all channels; counting resumes on the next edge.
- pause = 1 (sync = 0): acc held, cen <= 0. On release, the pulse train continues exactly where it stopped.
- Count step:
  - inc = (turbo & TURBO_EN) ? num_i<<1 : num_i, ACC_W+1 bits.
  - sum = acc + inc, ACC_W+2 bits.
- den = 0: channel disabled; acc <= 0, cen_i <= 0.
- num_i = 0: acc unchanged, no pulses.
- inc >= den (den != 0): saturate; cen_i <= 1 every counting cycle, acc <= 0.
- Otherwise:
  - sum >= den: cen_i <= 1. acc <= sum-den, or 0 if sum-den >= den (this covers den lowered mid-run).
  - sum < den: cen_i <= 0, acc <= sum.
- Latency: cen_i is registered and is high for the cycle following the edge that crossed den. Starting from acc = 0 with num = 1, den = D, the first pulse follows the D-th counting edge; period D thereafter.
- num, den and turbo are sampled every edge. Changes take effect on the next edge without resetting acc.
- Never more than one pulse per channel per cycle. Long-run pulse count over den cycles = min(inc, den).
- cen_any <= OR of the next cen values, so it is aligned with cen.

Test Plan:
- num0=1, den=4, no pause/turbo -> cen[0] high after edges 4, 8, 12...; num1=1 -> same. With den=12, num1 set for 2 MHz -> cen[1] every 12 cycles.
- num0=3, den=8 -> pulses after edges 3, 6, 8, then repeating every 8 (3 per 8 cycles). acc sequence 3, 6, 1, 4, 7, 2, 5, 0.
- turbo=1, num0=1, den=4 -> cen[0] every 2 cycles. TURBO_EN=0 build -> still every 4. num0=3, den=4 with turbo -> saturates, cen[0] every cycle.
- Run num=1, den=4 to acc=2; hold pause 5 cycles -> cen=0 throughout, next pulse 2 counting edges after release. Assert sync at acc=3 -> next pulse 4 edges later.
- den=0 -> cen=0 forever. den lowered 8->2 while acc=7 -> one pulse next edge, acc=0, then period 2.
- Assert reset_n low asynchronously mid-cycle while cen=1 -> cen and cen_any 0 before the next edge. Release -> first pulse after D edges.
